bcd_stopwatch_multi: RTL and testbench



---
 rtl/bcd_stopwatch_multi_pkg.sv | 20 ++
 rtl/bcd_stopwatch_multi_if.sv | 46 ++++
 rtl/bcd_stopwatch_multi_digit_cell.sv | 47 ++++
 rtl/bcd_stopwatch_multi.sv | 169 ++++++++++++++++
 tb/tb_bcd_stopwatch_multi.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_stopwatch_multi_pkg.sv
// Shared types and helpers for the multi-digit BCD stopwatch.
// Holds the FSM state encoding, BCD digit constants and the preset clamp.
package bcd_sw_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_t;

  // Nibbles above 9 are forced to 9 so every digit stays legal BCD.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_multi_if.sv
// Key/preset inputs and display/status outputs of the stopwatch.
// master = key pulse generators side, slave = stopwatch core.
interface bcd_stopwatch_multi_if
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS = 4
);

  logic                      key_rst_en;
  logic                      key_ps_en;
  logic                      key_lap_en;
  logic                      mode_down;
  logic [BCD_W*DIGITS-1:0]   preset_in;
  logic [BCD_W*DIGITS-1:0]   digits_out;
  logic                      running;
  logic                      lap_active;
  logic                      ovf;
  logic                      done;

  modport master (
    output key_rst_en,
    output key_ps_en,
    output key_lap_en,
    output mode_down,
    output preset_in,
    input  digits_out,
    input  running,
    input  lap_active,
    input  ovf,
    input  done
  );

  modport slave (
    input  key_rst_en,
    input  key_ps_en,
    input  key_lap_en,
    input  mode_down,
    input  preset_in,
    output digits_out,
    output running,
    output lap_active,
    output ovf,
    output done
  );

endinterface

// File: rtl/bcd_stopwatch_multi_digit_cell.sv
// One BCD digit of the counter chain: synchronous load (clamped) or an
// up/down step gated by the carry/borrow coming from the lower digit.
module bcd_digit_cell
  import bcd_sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             step,
  input  logic             down,
  input  logic             cin,
  output logic             cout,
  output logic [BCD_W-1:0] q
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;
  logic             at_edge;

  // at_edge marks the digit value that rolls over and propagates to the next digit.
  always_comb begin
    at_edge = down ? (q_q == '0) : (q_q == BCD_MAX);
    cout    = cin && at_edge;
    q_d     = q_q;
    if (load) begin
      q_d = bcd_clamp(load_val);
    end else if (step && cin) begin
      if (down) begin
        q_d = at_edge ? BCD_MAX : (q_q - BCD_W'(1));
      end else begin
        q_d = at_edge ? '0 : (q_q + BCD_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_stopwatch_multi.sv
// N-digit BCD up/down stopwatch with tick prescaler, lap freeze and
// countdown-done pulse; drives the packed digit bus for the 7-seg scanner.
module bcd_stopwatch_multi
  import bcd_sw_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10,
  parameter int UP_WRAP  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_stopwatch_multi_if.slave bus
);

  localparam int               CNT_W     = BCD_W * DIGITS;
  localparam int               PSC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(TICK_DIV - 1);

  sw_state_t        state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] lap_q, lap_d;
  logic             lap_active_q, lap_active_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_vec;
  logic [DIGITS:0]  chain;
  logic             cnt_load;
  logic             cnt_zero;
  logic             cnt_step;
  logic             tick;
  logic             at_limit;
  logic             at_one;

  assign chain[0] = 1'b1;
  assign load_vec = cnt_zero ? '0 : bus.preset_in;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (load_vec[i*BCD_W +: BCD_W]),
      .step     (cnt_step),
      .down     (mode_q),
      .cin      (chain[i]),
      .cout     (chain[i+1]),
      .q        (count[i*BCD_W +: BCD_W])
    );
  end

  // The end of the chain is high at all-9s counting up or all-0s counting down.
  assign at_limit = chain[DIGITS];
  assign at_one   = (count == CNT_W'(1));
  assign tick     = (state_q == ST_RUN) && (psc_q == PSC_LAST);

  always_comb begin
    state_d      = state_q;
    psc_d        = psc_q;
    mode_d       = mode_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_zero     = 1'b0;
    cnt_step     = 1'b0;

    if (bus.key_rst_en) begin
      state_d      = ST_IDLE;
      psc_d        = '0;
      lap_active_d = 1'b0;
      ovf_d        = 1'b0;
      cnt_load     = 1'b1;
      cnt_zero     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          mode_d       = bus.mode_down;
          cnt_load     = 1'b1;
          cnt_zero     = !bus.mode_down;
          ovf_d        = 1'b0;
          lap_active_d = 1'b0;
          if (bus.key_ps_en) begin
            psc_d = '0;
            if (bus.mode_down && (bus.preset_in == '0)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          psc_d = tick ? '0 : (psc_q + PSC_W'(1));
          if (bus.key_ps_en) begin
            state_d = ST_PAUSE;
          end
          // Reaching zero in down mode overrides a simultaneous pause.
          if (tick) begin
            if (!mode_q) begin
              if (at_limit) begin
                ovf_d    = 1'b1;
                cnt_step = (UP_WRAP != 0);
              end else begin
                cnt_step = 1'b1;
              end
            end else if (!at_limit) begin
              cnt_step = 1'b1;
              if (at_one) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (bus.key_ps_en) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (bus.key_lap_en && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_d        = count;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      psc_q        <= '0;
      mode_q       <= 1'b0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      psc_q        <= psc_d;
      mode_q       <= mode_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

  assign bus.digits_out = lap_active_q ? lap_q : count;
  assign bus.running    = (state_q == ST_RUN);
  assign bus.lap_active = lap_active_q;
  assign bus.ovf        = ovf_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_bcd_stopwatch_multi.sv
// Directed bench: a 4-digit stopwatch plus two 2-digit instances that
// exercise the up-mode wrap and saturate boundaries.
module tb_bcd_stopwatch_multi;

  localparam int K_PS     = 0;
  localparam int K_LAP    = 1;
  localparam int K_RST    = 2;
  localparam int K_RST_PS = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_stopwatch_multi_if #(.DIGITS(4)) sw_m ();
  bcd_stopwatch_multi_if #(.DIGITS(2)) sw_w ();
  bcd_stopwatch_multi_if #(.DIGITS(2)) sw_s ();

  bcd_stopwatch_multi #(.DIGITS(4), .TICK_DIV(4), .UP_WRAP(1)) u_dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_m)
  );

  bcd_stopwatch_multi #(.DIGITS(2), .TICK_DIV(4), .UP_WRAP(1)) u_dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_w)
  );

  bcd_stopwatch_multi #(.DIGITS(2), .TICK_DIV(4), .UP_WRAP(0)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Holds the chosen key(s) high for exactly one rising edge; target 0 = 4-digit DUT.
  task automatic applyStimulus(input int key, input int target);
    logic ps;
    logic lap;
    logic rst;
    ps  = (key == K_PS) || (key == K_RST_PS);
    lap = (key == K_LAP);
    rst = (key == K_RST) || (key == K_RST_PS);
    if (target == 0) begin
      sw_m.key_ps_en  = ps;
      sw_m.key_lap_en = lap;
      sw_m.key_rst_en = rst;
    end else begin
      sw_w.key_ps_en  = ps;
      sw_w.key_lap_en = lap;
      sw_w.key_rst_en = rst;
      sw_s.key_ps_en  = ps;
      sw_s.key_lap_en = lap;
      sw_s.key_rst_en = rst;
    end
    @(negedge clk);
    sw_m.key_ps_en  = 1'b0;
    sw_m.key_lap_en = 1'b0;
    sw_m.key_rst_en = 1'b0;
    sw_w.key_ps_en  = 1'b0;
    sw_w.key_lap_en = 1'b0;
    sw_w.key_rst_en = 1'b0;
    sw_s.key_ps_en  = 1'b0;
    sw_s.key_lap_en = 1'b0;
    sw_s.key_rst_en = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sw_m.key_ps_en = 1'b0; sw_m.key_lap_en = 1'b0; sw_m.key_rst_en = 1'b0;
    sw_m.mode_down = 1'b0; sw_m.preset_in  = 16'h0000;
    sw_w.key_ps_en = 1'b0; sw_w.key_lap_en = 1'b0; sw_w.key_rst_en = 1'b0;
    sw_w.mode_down = 1'b0; sw_w.preset_in  = 8'h00;
    sw_s.key_ps_en = 1'b0; sw_s.key_lap_en = 1'b0; sw_s.key_rst_en = 1'b0;
    sw_s.mode_down = 1'b0; sw_s.preset_in  = 8'h00;

    // Reset state
    waitCycles(1);
    checkOutput("rst_digits", 32'(sw_m.digits_out), 32'h0);
    checkOutput("rst_running", 32'(sw_m.running), 32'h0);
    checkOutput("rst_lap", 32'(sw_m.lap_active), 32'h0);
    checkOutput("rst_ovf", 32'(sw_m.ovf), 32'h0);
    checkOutput("rst_done", 32'(sw_m.done), 32'h0);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("idle_digits", 32'(sw_m.digits_out), 32'h0);

    // Run 40 clocks, pause for 100, resume without losing the partial tick
    applyStimulus(K_PS, 0);
    checkOutput("start_running", 32'(sw_m.running), 32'h1);
    waitCycles(40);
    checkOutput("run40_digits", 32'(sw_m.digits_out), 32'h0010);
    checkOutput("run40_running", 32'(sw_m.running), 32'h1);
    applyStimulus(K_PS, 0);
    checkOutput("pause_running", 32'(sw_m.running), 32'h0);
    waitCycles(100);
    checkOutput("pause_hold", 32'(sw_m.digits_out), 32'h0010);
    applyStimulus(K_PS, 0);
    checkOutput("resume_running", 32'(sw_m.running), 32'h1);
    waitCycles(2);
    checkOutput("resume_pre_tick", 32'(sw_m.digits_out), 32'h0010);
    waitCycles(1);
    checkOutput("resume_tick", 32'(sw_m.digits_out), 32'h0011);
    applyStimulus(K_RST, 0);
    checkOutput("krst_digits", 32'(sw_m.digits_out), 32'h0);
    checkOutput("krst_running", 32'(sw_m.running), 32'h0);

    // Lap freeze and release
    applyStimulus(K_PS, 0);
    waitCycles(20);
    checkOutput("lap_pre", 32'(sw_m.digits_out), 32'h0005);
    applyStimulus(K_LAP, 0);
    checkOutput("lap_active_on", 32'(sw_m.lap_active), 32'h1);
    checkOutput("lap_frozen0", 32'(sw_m.digits_out), 32'h0005);
    waitCycles(40);
    checkOutput("lap_frozen40", 32'(sw_m.digits_out), 32'h0005);
    applyStimulus(K_LAP, 0);
    checkOutput("lap_active_off", 32'(sw_m.lap_active), 32'h0);
    checkOutput("lap_live", 32'(sw_m.digits_out), 32'h0015);

    // Same-cycle clear + start/pause, then asynchronous reset mid-run
    applyStimulus(K_RST_PS, 0);
    checkOutput("rstps_digits", 32'(sw_m.digits_out), 32'h0);
    checkOutput("rstps_running", 32'(sw_m.running), 32'h0);
    applyStimulus(K_PS, 0);
    waitCycles(8);
    checkOutput("prerst_digits", 32'(sw_m.digits_out), 32'h0002);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_digits", 32'(sw_m.digits_out), 32'h0);
    checkOutput("async_running", 32'(sw_m.running), 32'h0);
    checkOutput("async_done", 32'(sw_m.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(1);

    // Countdown from 3
    sw_m.mode_down = 1'b1;
    sw_m.preset_in = 16'h0003;
    waitCycles(1);
    checkOutput("down_preload", 32'(sw_m.digits_out), 32'h0003);
    applyStimulus(K_PS, 0);
    waitCycles(3);
    checkOutput("down_hold3", 32'(sw_m.digits_out), 32'h0003);
    waitCycles(1);
    checkOutput("down_2", 32'(sw_m.digits_out), 32'h0002);
    waitCycles(4);
    checkOutput("down_1", 32'(sw_m.digits_out), 32'h0001);
    waitCycles(3);
    checkOutput("down_1_nodone", 32'(sw_m.done), 32'h0);
    waitCycles(1);
    checkOutput("down_0", 32'(sw_m.digits_out), 32'h0000);
    checkOutput("done_pulse", 32'(sw_m.done), 32'h1);
    checkOutput("done_running", 32'(sw_m.running), 32'h0);
    waitCycles(1);
    checkOutput("done_pulse_end", 32'(sw_m.done), 32'h0);
    applyStimulus(K_PS, 0);
    checkOutput("done_ps_ignored", 32'(sw_m.running), 32'h0);
    applyStimulus(K_LAP, 0);
    checkOutput("done_lap_ignored", 32'(sw_m.lap_active), 32'h0);
    waitCycles(8);
    checkOutput("done_hold0", 32'(sw_m.digits_out), 32'h0);
    checkOutput("done_no_repulse", 32'(sw_m.done), 32'h0);
    applyStimulus(K_RST, 0);
    waitCycles(1);
    checkOutput("done_to_idle", 32'(sw_m.digits_out), 32'h0003);

    // Zero preset goes straight to DONE; illegal nibble clamps to 9
    sw_m.preset_in = 16'h0000;
    waitCycles(1);
    applyStimulus(K_PS, 0);
    checkOutput("zero_done", 32'(sw_m.done), 32'h1);
    checkOutput("zero_running", 32'(sw_m.running), 32'h0);
    waitCycles(1);
    checkOutput("zero_done_end", 32'(sw_m.done), 32'h0);
    applyStimulus(K_RST, 0);
    sw_m.preset_in = 16'h00C2;
    waitCycles(1);
    checkOutput("clamp_load", 32'(sw_m.digits_out), 32'h0092);
    applyStimulus(K_PS, 0);
    waitCycles(4);
    checkOutput("clamp_step", 32'(sw_m.digits_out), 32'h0091);
    applyStimulus(K_RST, 0);
    sw_m.mode_down = 1'b0;

    // 2-digit up-mode boundary: wrap vs saturate
    applyStimulus(K_PS, 1);
    waitCycles(392);
    checkOutput("w_98", 32'(sw_w.digits_out), 32'h98);
    checkOutput("s_98", 32'(sw_s.digits_out), 32'h98);
    checkOutput("w_98_ovf", 32'(sw_w.ovf), 32'h0);
    waitCycles(4);
    checkOutput("w_99", 32'(sw_w.digits_out), 32'h99);
    checkOutput("s_99_ovf", 32'(sw_s.ovf), 32'h0);
    waitCycles(4);
    checkOutput("w_wrap", 32'(sw_w.digits_out), 32'h00);
    checkOutput("w_wrap_ovf", 32'(sw_w.ovf), 32'h1);
    checkOutput("s_sat", 32'(sw_s.digits_out), 32'h99);
    checkOutput("s_sat_ovf", 32'(sw_s.ovf), 32'h1);
    waitCycles(4);
    checkOutput("w_after_wrap", 32'(sw_w.digits_out), 32'h01);
    checkOutput("w_ovf_sticky", 32'(sw_w.ovf), 32'h1);
    checkOutput("s_still_sat", 32'(sw_s.digits_out), 32'h99);
    applyStimulus(K_RST, 1);
    checkOutput("w_ovf_clr", 32'(sw_w.ovf), 32'h0);
    checkOutput("s_ovf_clr", 32'(sw_s.ovf), 32'h0);
    checkOutput("s_clr_digits", 32'(sw_s.digits_out), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
